// File: rtl/logic_serial_unit_if.sv
// Handshake and operand/result bundle for logic_serial_unit.
// The master side issues operations; the slave side (the unit) reports results.
interface logic_serial_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output start, op, in1, in2,
        input  out, busy, done, zero
    );

    modport slave (
        input  start, op, in1, in2,
        output out, busy, done, zero
    );
endinterface

// File: rtl/logic_serial_unit.sv
// Bitwise AND/OR/XOR/NOR unit that processes LANE_W bits per clock, LSB lane first.
// state | meaning: IDLE = waiting for start; BUSY = one lane per edge; DONE = result valid, one-cycle pulse.
module logic_serial_unit #(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_serial_unit_if.slave   bus
);
    localparam int LANES = WIDTH / LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   part_q;
    logic [WIDTH-1:0]   out_q;
    logic               zero_q;

    logic [IDX_W-1:0]   base;
    logic [LANE_W-1:0]  lane_a;
    logic [LANE_W-1:0]  lane_b;
    logic [LANE_W-1:0]  lane_res;
    logic [WIDTH-1:0]   part_nxt;
    logic               last_lane;

    // Lane datapath: only the lane addressed by the counter is touched.
    always_comb begin
        base      = IDX_W'(cnt_q) * IDX_W'(LANE_W);
        lane_a    = a_q[base +: LANE_W];
        lane_b    = b_q[base +: LANE_W];
        last_lane = (cnt_q == CNT_W'(LANES - 1));
        case (op_q)
            2'b00:   lane_res = lane_a & lane_b;
            2'b01:   lane_res = lane_a | lane_b;
            2'b10:   lane_res = lane_a ^ lane_b;
            default: lane_res = ~(lane_a | lane_b);
        endcase
        part_nxt               = part_q;
        part_nxt[base +: LANE_W] = lane_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = bus.start ? BUSY : IDLE;
            BUSY:       state_d = last_lane ? DONE : BUSY;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 2'b00;
            cnt_q  <= '0;
            part_q <= '0;
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q    <= bus.in1;
                        b_q    <= bus.in2;
                        op_q   <= bus.op;
                        cnt_q  <= '0;
                        part_q <= '0;
                    end
                end
                BUSY: begin
                    part_q <= part_nxt;
                    if (last_lane) begin
                        cnt_q  <= '0;
                        out_q  <= part_nxt;
                        zero_q <= (part_nxt == '0);
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.zero = zero_q;
    assign bus.busy = (state_q == BUSY);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_logic_serial_unit.sv
// Self-checking bench for logic_serial_unit: directed scenarios plus randomized ops
// checked against a whole-word reference model.
module tb_logic_serial_unit;
    localparam int WIDTH   = 32;
    localparam int LANE_W  = 8;
    localparam int LATENCY = WIDTH / LANE_W;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [WIDTH-1:0] prev_out;
    logic             prev_zero;

    logic_serial_unit_if #(.WIDTH(WIDTH)) bus ();

    logic_serial_unit #(.WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_fn(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic drive(input logic s, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.start = s;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 2'($urandom), $urandom, $urandom);
        #2;
        vectors++;
        if (bus.out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state out=%h busy=%b done=%b zero=%b required out=0 busy=0 done=0 zero=1",
                     bus.out, bus.busy, bus.done, bus.zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_idle busy=%b done=%b zero=%b required 0 0 1",
                     bus.busy, bus.done, bus.zero);
        end
        prev_out  = '0;
        prev_zero = 1'b1;
    endtask

    task automatic test_or;
        drive(1'b1, 2'b01, 32'h00FF00F0, 32'h0F0000FF);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            vectors++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.out !== prev_out) begin
                miscompares++;
                $display("FAIL or_busy cycle=%0d busy=%b done=%b out=%h required busy=1 done=0 out=%h",
                         i, bus.busy, bus.done, bus.out, prev_out);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== 32'h0FFF00FF || bus.zero !== 1'b0) begin
            miscompares++;
            $display("FAIL or_result done=%b busy=%b out=%h zero=%b required done=1 busy=0 out=0fff00ff zero=0",
                     bus.done, bus.busy, bus.out, bus.zero);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL or_done_pulse done=%b required 0", bus.done);
        end
        prev_out  = 32'h0FFF00FF;
        prev_zero = 1'b0;
    endtask

    task automatic test_and_zero;
        drive(1'b1, 2'b00, 32'hF0F0F0F0, 32'h0F0F0F0F);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            vectors++;
            if (bus.busy !== 1'b1 || bus.out !== prev_out || bus.zero !== prev_zero) begin
                miscompares++;
                $display("FAIL and_busy cycle=%0d busy=%b out=%h zero=%b required busy=1 out=%h zero=%b",
                         i, bus.busy, bus.out, bus.zero, prev_out, prev_zero);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.out !== 32'h0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL and_result done=%b out=%h zero=%b required done=1 out=0 zero=1",
                     bus.done, bus.out, bus.zero);
        end
        @(negedge clk);
        prev_out  = 32'h0;
        prev_zero = 1'b1;
    endtask

    task automatic test_xor_ignore_start;
        int dones;
        dones = 0;
        drive(1'b1, 2'b10, 32'hFFFFFFFF, 32'h12345678);
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h0, 32'h12345678);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 2; i <= LATENCY + 4; i++) begin
            if (bus.done === 1'b1) dones++;
            if (i == LATENCY + 1) begin
                vectors++;
                if (bus.done !== 1'b1 || bus.out !== 32'hEDCBA987) begin
                    miscompares++;
                    $display("FAIL xor_result done=%b out=%h required done=1 out=edcba987",
                             bus.done, bus.out);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL xor_done_count got=%0d required=1", dones);
        end
        prev_out  = 32'hEDCBA987;
        prev_zero = 1'b0;
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 2'b11, 32'h0, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (LATENCY) @(negedge clk);
        vectors++;
        if (bus.done !== 1'b1 || bus.out !== 32'hFFFFFFFF || bus.zero !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first done=%b out=%h zero=%b required done=1 out=ffffffff zero=0",
                     bus.done, bus.out, bus.zero);
        end
        drive(1'b1, 2'b01, 32'h1, 32'h2);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            vectors++;
            if (bus.busy !== 1'b1 || bus.out !== 32'hFFFFFFFF) begin
                miscompares++;
                $display("FAIL b2b_busy cycle=%0d busy=%b out=%h required busy=1 out=ffffffff",
                         i, bus.busy, bus.out);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.out !== 32'h3 || bus.zero !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second done=%b out=%h zero=%b required done=1 out=00000003 zero=0",
                     bus.done, bus.out, bus.zero);
        end
        @(negedge clk);
        prev_out  = 32'h3;
        prev_zero = 1'b0;
    endtask

    task automatic test_reset_mid_busy;
        int dones;
        dones = 0;
        drive(1'b1, 2'b01, 32'hA5A5A5A5, 32'h5A5A0000);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_busy out=%h busy=%b done=%b zero=%b required out=0 busy=0 done=0 zero=1",
                     bus.out, bus.busy, bus.done, bus.zero);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * LATENCY) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0 || bus.out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_abort activity=%0d out=%h required activity=0 out=0", dones, bus.out);
        end
        prev_out  = '0;
        prev_zero = 1'b1;
    endtask

    task automatic test_idle_hold;
        drive(1'b1, 2'b10, 32'hCAFE0000, 32'h0000BEEF);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (LATENCY) @(negedge clk);
        prev_out  = 32'hCAFEBEEF;
        prev_zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b0, 2'($urandom), $urandom, $urandom);
            vectors++;
            if (bus.out !== prev_out || bus.zero !== prev_zero || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold cycle=%0d out=%h zero=%b done=%b busy=%b required out=%h zero=%b done=0 busy=0",
                         i, bus.out, bus.zero, bus.done, bus.busy, prev_out, prev_zero);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]       op;
        logic [WIDTH-1:0] a, b, exp;
        int               cycles;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) b = ~a;
            exp = ref_fn(op, a, b);
            @(negedge clk);
            drive(1'b1, op, a, b);
            @(negedge clk);
            cycles = 0;
            while (bus.done !== 1'b1 && cycles < 4 * LATENCY) begin
                drive(1'($urandom), 2'($urandom), $urandom, $urandom);
                vectors++;
                if (bus.busy !== 1'b1 || bus.out !== prev_out || bus.zero !== prev_zero) begin
                    miscompares++;
                    $display("FAIL rand_busy op=%0d busy=%b out=%h zero=%b required busy=1 out=%h zero=%b",
                             n, bus.busy, bus.out, bus.zero, prev_out, prev_zero);
                end
                cycles++;
                @(negedge clk);
            end
            bus.start = 1'b0;
            vectors++;
            if (cycles != LATENCY || bus.done !== 1'b1 || bus.out !== exp || bus.zero !== (exp == '0)) begin
                miscompares++;
                $display("FAIL rand_result op=%0d busy_cycles=%0d done=%b out=%h zero=%b required busy_cycles=%0d done=1 out=%h zero=%b",
                         n, cycles, bus.done, bus.out, bus.zero, LATENCY, exp, (exp == '0));
            end
            prev_out  = exp;
            prev_zero = (exp == '0);
            @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_or();
        test_and_zero();
        test_xor_ignore_start();
        test_back_to_back();
        test_reset_mid_busy();
        test_idle_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/logic_serial_unit.md
LOGIC_SERIAL_UNIT -- requirements
Module: logic_serial_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter LANE_W, default 8: bits processed per cycle; WIDTH SHALL be an integer multiple of LANE_W.
REQ-003 clk  input  1: single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 start  input  1: request a new operation; sampled on the clk rising edge.
REQ-006 op  input  2: operation select, 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 in1  input  WIDTH: operand A, sampled with start.
REQ-008 in2  input  WIDTH: operand B, sampled with start.
REQ-009 out  output  WIDTH: registered result of the last completed operation.
REQ-010 busy  output  1: high while lanes are being processed.
REQ-011 done  output  1: one-cycle completion pulse.
REQ-012 zero  output  1: registered flag, high when out is all zeros.

Function
REQ-013 The block SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE or DONE, start=1 at a clk edge SHALL:
- capture in1, in2 and op into internal registers;
- clear the lane counter to 0 and the partial-result register to 0;
- enter BUSY.
REQ-015 In IDLE or DONE, start=0 at a clk edge SHALL move the block to IDLE.
REQ-016 In BUSY, each clk edge SHALL process lane k = counter, covering bits [k*LANE_W +: LANE_W]:
- apply the captured op to the captured operands' lane-k bits;
- write the lane result into bits k of the partial result;
- increment the counter.
REQ-017 Lanes SHALL be processed in order from least significant (k=0) to most significant (k=WIDTH/LANE_W-1).
REQ-018 On the edge that processes the last lane, the block SHALL:
- load out with the full result, including that lane;
- load zero with (result == 0);
- enter DONE.
REQ-019 Latency: with defaults, done SHALL be high in the cycle after the 4th edge following the edge that sampled start; in general, WIDTH/LANE_W edges after that edge.
REQ-020 done SHALL equal 1 exactly while the state is DONE, so each operation gives a single-cycle pulse.
REQ-021 busy SHALL equal 1 exactly while the state is BUSY.
REQ-022 start asserted during BUSY SHALL be ignored; it SHALL NOT restart the operation or corrupt the captured operands.
REQ-023 Changes on in1, in2 or op after the start edge SHALL NOT affect the running operation.
REQ-024 start=1 while in DONE SHALL be accepted, giving back-to-back operations with no IDLE cycle between them.
REQ-025 out and zero SHALL hold their values from the previous completion until the next completion; they SHALL NOT change during BUSY.
REQ-026 The lane counter SHALL wrap to 0 after the last lane, and no lane index outside 0..WIDTH/LANE_W-1 SHALL ever be addressed.
REQ-027 NOR SHALL be the bitwise inverse of OR, computed lane by lane.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force:
- state to IDLE;
- out, the partial result, the captured operands, the captured op and the counter to 0;
- busy=0, done=0, zero=1.
REQ-029 rst asserted during BUSY SHALL abort the operation; no done pulse SHALL follow for it.
REQ-030 After rst deasserts, the first start SHALL operate normally.

Verification
REQ-031 The bench SHALL cover: OR, in1=0x00FF00F0, in2=0x0F0000FF, start for 1 cycle -> busy for 4 cycles, then done=1 for 1 cycle, out=0x0FFF00FF, zero=0.
REQ-032 The bench SHALL cover: AND, in1=0xF0F0F0F0, in2=0x0F0F0F0F -> out=0x00000000, zero=1, done pulse after 4 busy cycles.
REQ-033 The bench SHALL cover: XOR, in1=0xFFFFFFFF, in2=0x12345678, with in1 changed to 0 and start pulsed again during BUSY -> out=0xEDCBA987 after the original latency, and exactly one done pulse.
REQ-034 The bench SHALL cover: NOR, in1=0, in2=0, followed in the DONE cycle by OR, in1=1, in2=2 -> first out=0xFFFFFFFF, then out=0x00000003 after 4 more busy cycles, with no IDLE cycle between.
REQ-035 The bench SHALL cover: rst asserted mid-BUSY (after 2 lanes) between clk edges -> out=0, busy=0, done=0, zero=1 immediately, and no later done pulse.
REQ-036 The bench SHALL cover: a completed operation followed by an idle period -> out and zero stable, done=0, busy=0.
